// File: rtl/fifo_wr_arb_pkg.sv
// rtl/fifo_wr_arb_pkg.sv - shared arbiter/FIFO encodings and sizing constants
package fifo_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    GNT0        = 2'b01,
    GNT1        = 2'b10,
    ARB_ILLEGAL = 2'b11
  } arb_state_e;

  // FIFO control encodings, shared with the downstream synchronous FIFO
  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5
  } fifo_state_e;

  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_CNT_W  = 4;
  localparam int BURST_CNT_W = 4;
  localparam int STALL_CNT_W = 8;

  function automatic logic [BURST_CNT_W-1:0] burst_last(input int len);
    return BURST_CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_ns.sv
// rtl/fifo_wr_arb_ns.sv - combinational next-state, burst count and last-served logic
module fifo_wr_arb_ns
  import fifo_wr_arb_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic [1:0]             state_i,
  input  logic                   req0_i,
  input  logic                   req1_i,
  input  logic                   fifo_full_i,
  input  logic [BURST_CNT_W-1:0] burst_cnt_i,
  input  logic                   last_srv_i,
  output logic [1:0]             state_o,
  output logic [BURST_CNT_W-1:0] burst_cnt_o,
  output logic                   last_srv_o
);

  localparam logic [BURST_CNT_W-1:0] BURST_LAST = burst_last(BURST_LEN);

  logic own_is1;
  logic own_req;
  logic oth_req;
  logic wr;
  logic release_grant;

  always_comb begin
    state_o       = IDLE;
    burst_cnt_o   = '0;
    last_srv_o    = last_srv_i;
    own_is1       = 1'b0;
    own_req       = 1'b0;
    oth_req       = 1'b0;
    wr            = 1'b0;
    release_grant = 1'b0;
    case (arb_state_e'(state_i))
      IDLE: begin
        // On a tie the producer that was not served last wins
        if (req0_i && (!req1_i || last_srv_i)) begin
          state_o = GNT0;
        end else if (req1_i) begin
          state_o = GNT1;
        end
      end
      GNT0, GNT1: begin
        own_is1       = (state_i == GNT1);
        own_req       = own_is1 ? req1_i : req0_i;
        oth_req       = own_is1 ? req0_i : req1_i;
        wr            = own_req & ~fifo_full_i;
        release_grant = ~own_req | (wr & (burst_cnt_i == BURST_LAST));
        if (release_grant) begin
          last_srv_o = own_is1;
          if (oth_req) begin
            state_o = own_is1 ? GNT0 : GNT1;
          end else begin
            state_o = IDLE;
          end
        end else begin
          // Holding while full keeps the count so the burst resumes where it stopped
          state_o     = state_i;
          burst_cnt_o = burst_cnt_i + {{(BURST_CNT_W-1){1'b0}}, wr};
        end
      end
      default: begin
        state_o = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin two-producer FIFO write-port arbiter; FIFO_WR_ARB_STALL_CNT_EN enables the stall counter
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic              fifo_full,
  output logic              gnt0,
  output logic              gnt1,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              ack0,
  output logic              ack1,
  output logic [7:0]        stall_cnt
);

  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q;
  logic [BURST_CNT_W-1:0] burst_cnt_d;
  logic                   last_srv_q;
  logic                   last_srv_d;
  logic                   own_req;

  fifo_wr_arb_ns #(
    .BURST_LEN (BURST_LEN)
  ) u_ns (
    .state_i     (state_q),
    .req0_i      (req0),
    .req1_i      (req1),
    .fifo_full_i (fifo_full),
    .burst_cnt_i (burst_cnt_q),
    .last_srv_i  (last_srv_q),
    .state_o     (state_d),
    .burst_cnt_o (burst_cnt_d),
    .last_srv_o  (last_srv_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      last_srv_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_srv_q  <= last_srv_d;
    end
  end

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // Grants come straight from the state flops, so async reset kills the write at once
  assign own_req    = (gnt0 & req0) | (gnt1 & req1);
  assign fifo_wr_en = own_req & ~fifo_full;
  assign ack0       = gnt0 & fifo_wr_en;
  assign ack1       = gnt1 & fifo_wr_en;
  assign fifo_din   = gnt1 ? din1 : din0;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (own_req && fifo_full && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_q <= stall_cnt_q + 8'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 8'h00;
`endif

endmodule
